branch_predictor_hybrid: RTL and testbench
==========================================

BRANCH_PREDICTOR_HYBRID -- requirements
Module: branch_predictor_hybrid

Interface
REQ-001 Parameter DATA_W, 64: PC and target width.
REQ-002 Parameter IDX_BITS, 10: table index width; each table holds 2^IDX_BITS entries.
REQ-003 Parameter HIST_BITS, 10: global history length, 2..IDX_BITS.
REQ-004 Parameter RAS_DEPTH, 8: return-address-stack entries, power of two, >=2.
REQ-005 Parameter CTR_INIT, 2'b10: init value of every selector and PHT counter.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pred_valid  in  1  fetch requests a prediction for pc this cycle.
REQ-009 pc  in  DATA_W  fetch PC.
REQ-010 pred_taken  out  1  predicted redirect.
REQ-011 pred_target  out  DATA_W  next fetch PC.
REQ-012 pred_ghr  out  HIST_BITS  speculative history used by this prediction (checkpoint for the pipeline).
REQ-013 ready  out  1  1 = tables initialised and predicting.
REQ-014 upd_valid  in  1  resolved control-flow instruction.
REQ-015 upd_pc, upd_target  in  DATA_W  resolved PC and actual target.
REQ-016 upd_taken  in  1  actual direction.
REQ-017 upd_type  in  2  00 cond branch, 01 jump, 10 call, 11 return.
REQ-018 upd_ghr  in  HIST_BITS  pred_ghr checkpoint carried with the instruction.
REQ-019 upd_mispredict  in  1  direction or target was mispredicted; qualified by upd_valid.

Function
REQ-020 Index = pc[IDX_BITS+1:2]; tag = pc[DATA_W-1:IDX_BITS+2]; gshare index = index XOR zero-extended spec_ghr (upd side: upd_ghr).
REQ-021 BTB entry = {valid, tag, type[1:0], target}; hit = valid AND tag match.
REQ-022 Prediction is combinational, same cycle: miss -> not taken; cond -> selector MSB 1 selects bimodal PHT1 MSB, 0 selects gshare PHT2 MSB; jump/call -> taken, BTB target; return -> taken with RAS top if RAS non-empty, else not taken.
REQ-023 pred_target = pred_taken ? chosen target : pc+4 (modulo 2^DATA_W); pred_ghr = spec_ghr before any shift.
REQ-024 Accepted prediction (pred_valid & ready & ~(upd_valid & upd_mispredict)): hit cond shifts predicted direction into spec_ghr LSB; hit call pushes pc+4; hit return with RAS non-empty pops.
REQ-025 RAS circular: push when full overwrites oldest entry, count saturates at RAS_DEPTH; pop when empty leaves state unchanged.
REQ-026 Update (upd_valid & ready): for cond only, PHT1[upd index] and PHT2[upd gshare index] saturate toward upd_taken (00..11); selector increments if only PHT1 correct, decrements if only PHT2 correct, saturating, else holds.
REQ-027 Update with upd_taken=1 writes BTB[upd index] = {1, upd tag, upd_type, upd_target}; upd_taken=0 leaves BTB unchanged.
REQ-028 Mispredict: spec_ghr <= {upd_ghr[HIST_BITS-2:0], upd_taken} for cond, upd_ghr otherwise; same-cycle prediction-side GHR shift and RAS op suppressed; RAS not otherwise repaired.
REQ-029 Same-index read and write in one cycle: prediction sees pre-edge contents.
REQ-030 Two FSM states INIT, RUN; INIT writes entry init_idx of all tables (BTB valid=0, counters=CTR_INIT) per cycle, init_idx+1; after entry 2^IDX_BITS-1 -> RUN.
REQ-031 In INIT: ready=0, pred_taken=0, pred_target=pc+4, updates and prediction-side state changes ignored.

Reset
REQ-032 reset asserted asynchronously: state=INIT, init_idx=0, spec_ghr=0, RAS count and pointer 0, ready=0, pred_taken=0.
REQ-033 Reset asserted in RUN or mid-INIT restarts the full INIT sweep from index 0.
REQ-034 RUN reached exactly 2^IDX_BITS rising edges after reset deassertion; ready=1 from that cycle.

Verification (IDX_BITS=4, HIST_BITS=4, RAS_DEPTH=4, DATA_W=64)
REQ-035 Release reset -> ready=0 for 16 cycles, then 1; pc=0x100 gives pred_taken=0, pred_target=0x104.
REQ-036 Update pc=0x40 cond taken target=0x80, upd_ghr=0 -> next cycle pc=0x40 with spec_ghr=0 predicts taken 0x80; two not-taken updates -> predicts 0x44.
REQ-037 BTB call at 0x10->0x200, return at 0x20C; predict 0x10 then 0x20C -> second target 0x14; five calls without return -> RAS count 4, oldest lost; pop on empty -> not taken.
REQ-038 spec_ghr=4'b1011; upd_mispredict cond, upd_ghr=4'b0010, upd_taken=1, same-cycle hit cond predicted -> spec_ghr=4'b0101, no shift.
REQ-039 Selector: PHT1 correct, PHT2 wrong for one cond PC, three updates -> selector 11 saturated; reverse case 3 updates -> 00.
REQ-040 Assert reset at cycle 8 of INIT and mid-RUN -> ready drops immediately, restarts 16-cycle sweep, prior BTB entries invalid.

Source files
------------

// File: rtl/branch_predictor_hybrid_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_hybrid_if
// Purpose  : Prediction request/response and branch-resolution update bundle
//            between the fetch/commit pipeline and the hybrid predictor.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_hybrid_if #(
  parameter int DATA_W    = 64,
  parameter int HIST_BITS = 10
);
  // Prediction side
  logic                 pred_valid;
  logic [DATA_W-1:0]    pc;
  logic                 pred_taken;
  logic [DATA_W-1:0]    pred_target;
  logic [HIST_BITS-1:0] pred_ghr;
  logic                 ready;
  // Resolution / update side
  logic                 upd_valid;
  logic [DATA_W-1:0]    upd_pc;
  logic [DATA_W-1:0]    upd_target;
  logic                 upd_taken;
  logic [1:0]           upd_type;
  logic [HIST_BITS-1:0] upd_ghr;
  logic                 upd_mispredict;

  modport master (
    output pred_valid, pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_type, upd_ghr, upd_mispredict,
    input  pred_taken, pred_target, pred_ghr, ready
  );

  modport slave (
    input  pred_valid, pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_type, upd_ghr, upd_mispredict,
    output pred_taken, pred_target, pred_ghr, ready
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_hybrid.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_hybrid
// Purpose  : Tournament (bimodal + gshare) direction predictor with a tagged
//            BTB and a circular return-address stack. Tables are cleared by a
//            one-entry-per-cycle sweep after reset.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_hybrid #(
  parameter int         DATA_W    = 64,
  parameter int         IDX_BITS  = 10,
  parameter int         HIST_BITS = 10,
  parameter int         RAS_DEPTH = 8,
  parameter logic [1:0] CTR_INIT  = 2'b10
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  branch_predictor_hybrid_if.slave  bp
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = DATA_W - IDX_BITS - 2;
  localparam int PTR_W   = $clog2(RAS_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] T_COND = 2'b00;
  localparam logic [1:0] T_JUMP = 2'b01;
  localparam logic [1:0] T_CALL = 2'b10;

  // Table storage (cleared by the init sweep, not by reset)
  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [ENTRIES];
  logic [1:0]        btb_type   [ENTRIES];
  logic [DATA_W-1:0] btb_target [ENTRIES];
  logic [1:0]        pht1       [ENTRIES];
  logic [1:0]        pht2       [ENTRIES];
  logic [1:0]        sel_ctr    [ENTRIES];
  logic [DATA_W-1:0] ras        [RAS_DEPTH];

  logic [0:0]           state, state_next;
  logic                 run, init_we;
  logic [IDX_BITS-1:0]  init_idx;
  logic [HIST_BITS-1:0] spec_ghr;
  logic [PTR_W-1:0]     ras_ptr;
  logic [CNT_W-1:0]     ras_cnt;

  function automatic logic [1:0] sat2(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  // FSM next state: leave INIT once the last table entry has been written
  always_comb begin
    state_next = state;
    if (state == ST_INIT && init_idx == {IDX_BITS{1'b1}}) state_next = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    run     = (state == ST_RUN);
    init_we = (state == ST_INIT);
  end

  // Init sweep index
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        init_idx <= '0;
    else if (init_we) init_idx <= init_idx + IDX_BITS'(1);
  end

  // ---------------- prediction side ----------------
  logic [IDX_BITS-1:0] pred_idx, pred_gidx;
  logic [TAG_W-1:0]    pred_tag;
  logic [DATA_W-1:0]   pc_plus4, ras_top, chosen_target;
  logic                pred_hit, taken;
  logic [1:0]          pred_type;

  assign pred_idx  = bp.pc[IDX_BITS+1:2];
  assign pred_tag  = bp.pc[DATA_W-1:IDX_BITS+2];
  assign pred_gidx = pred_idx ^ IDX_BITS'(spec_ghr);
  assign pc_plus4  = bp.pc + DATA_W'(4);
  assign pred_hit  = btb_valid[pred_idx] && (btb_tag[pred_idx] == pred_tag);
  assign pred_type = btb_type[pred_idx];
  assign ras_top   = ras[ras_ptr - PTR_W'(1)];

  // Direction/target choice from the BTB entry type
  always_comb begin
    taken         = 1'b0;
    chosen_target = btb_target[pred_idx];
    if (run && pred_hit) begin
      case (pred_type)
        T_COND:         taken = sel_ctr[pred_idx][1] ? pht1[pred_idx][1] : pht2[pred_gidx][1];
        T_JUMP, T_CALL: taken = 1'b1;
        default: begin
          taken         = (ras_cnt != '0);
          chosen_target = ras_top;
        end
      endcase
    end
  end

  assign bp.pred_taken  = taken;
  assign bp.pred_target = taken ? chosen_target : pc_plus4;
  assign bp.pred_ghr    = spec_ghr;
  assign bp.ready       = run;

  // ---------------- speculative state control ----------------
  logic mispredict, accept, ghr_shift, ras_push, ras_pop;

  assign mispredict = run & bp.upd_valid & bp.upd_mispredict;
  assign accept     = run & bp.pred_valid & ~mispredict;
  assign ghr_shift  = accept & pred_hit & (pred_type == T_COND);
  assign ras_push   = accept & pred_hit & (pred_type == T_CALL);
  assign ras_pop    = accept & pred_hit & (pred_type == 2'b11) & (ras_cnt != '0);

  // Speculative history and RAS pointers; a mispredict restores history from
  // the checkpoint and wins over any same-cycle prediction-side change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec_ghr <= '0;
      ras_ptr  <= '0;
      ras_cnt  <= '0;
    end else begin
      if (mispredict)
        spec_ghr <= (bp.upd_type == T_COND) ? {bp.upd_ghr[HIST_BITS-2:0], bp.upd_taken}
                                            : bp.upd_ghr;
      else if (ghr_shift)
        spec_ghr <= {spec_ghr[HIST_BITS-2:0], taken};
      if (ras_push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (ras_pop) begin
        ras_ptr <= ras_ptr - PTR_W'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

  // ---------------- update side ----------------
  logic [IDX_BITS-1:0] upd_idx, upd_gidx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_en, upd_cond, p1_ok, p2_ok;
  logic [1:0]          sel_new;

  assign upd_idx  = bp.upd_pc[IDX_BITS+1:2];
  assign upd_tag  = bp.upd_pc[DATA_W-1:IDX_BITS+2];
  assign upd_gidx = upd_idx ^ IDX_BITS'(bp.upd_ghr);
  assign upd_en   = run & bp.upd_valid;
  assign upd_cond = upd_en & (bp.upd_type == T_COND);
  assign p1_ok    = (pht1[upd_idx][1]  == bp.upd_taken);
  assign p2_ok    = (pht2[upd_gidx][1] == bp.upd_taken);

  // Selector trains only when exactly one component was right
  always_comb begin
    sel_new = sel_ctr[upd_idx];
    if (p1_ok && !p2_ok)      sel_new = sat2(sel_ctr[upd_idx], 1'b1);
    else if (!p1_ok && p2_ok) sel_new = sat2(sel_ctr[upd_idx], 1'b0);
  end

  // Table writes: init sweep, resolved-branch training, RAS push
  always_ff @(posedge clk) begin
    if (init_we) begin
      btb_valid[init_idx] <= 1'b0;
      pht1[init_idx]      <= CTR_INIT;
      pht2[init_idx]      <= CTR_INIT;
      sel_ctr[init_idx]   <= CTR_INIT;
    end else begin
      if (upd_cond) begin
        pht1[upd_idx]    <= sat2(pht1[upd_idx], bp.upd_taken);
        pht2[upd_gidx]   <= sat2(pht2[upd_gidx], bp.upd_taken);
        sel_ctr[upd_idx] <= sel_new;
      end
      if (upd_en && bp.upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_type[upd_idx]   <= bp.upd_type;
        btb_target[upd_idx] <= bp.upd_target;
      end
    end
    if (ras_push) ras[ras_ptr] <= pc_plus4;
  end

  // Byte-offset bits of the PCs carry no information for this predictor
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc[1:0], bp.upd_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_hybrid.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_hybrid
// Purpose  : Self-checking bench for branch_predictor_hybrid with a
//            behavioural reference model and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_hybrid;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_hybrid_if #(.DATA_W(64), .HIST_BITS(4)) bif ();

  branch_predictor_hybrid #(
    .DATA_W(64), .IDX_BITS(4), .HIST_BITS(4), .RAS_DEPTH(4), .CTR_INIT(2'b10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bp(bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit          m_ready;
  int          m_init;
  bit          mv   [16];
  logic [63:0] mtag [16];
  int          mtype[16];
  logic [63:0] mtgt [16];
  int          mp1  [16];
  int          mp2  [16];
  int          msel [16];
  int          mghr;
  logic [63:0] mras [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ready = 0;
    m_init  = 0;
    mghr    = 0;
    mras.delete();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; mp1[i] = 2; mp2[i] = 2; msel[i] = 2;
    end
  endfunction

  function automatic int idx_of(input logic [63:0] p);
    return int'((p >> 2) & 64'd15);
  endfunction

  function automatic void model_predict(input logic [63:0] p, output bit tk,
                                        output logic [63:0] tg, output bit hit, output int ty);
    int i;
    int ctr;
    i   = idx_of(p);
    hit = m_ready && mv[i] && (mtag[i] == (p >> 6));
    ty  = mtype[i];
    tk  = 0;
    tg  = p + 64'd4;
    if (hit) begin
      if (ty == 0) begin
        ctr = (msel[i] >= 2) ? mp1[i] : mp2[i ^ mghr];
        tk  = (ctr >= 2);
      end else if (ty == 3) begin
        tk = (mras.size() > 0);
      end else begin
        tk = 1;
      end
      if (tk) tg = (ty == 3) ? mras[$] : mtgt[i];
    end
  endfunction

  function automatic int sat_step(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic void model_step(input bit tk, input bit hit, input int ty);
    bit mis, acc, c1, c2, ut;
    int ui, gi, utype, ughr;
    if (!m_ready) begin
      m_init++;
      if (m_init == 16) m_ready = 1;
      return;
    end
    mis   = bif.upd_valid && bif.upd_mispredict;
    acc   = bif.pred_valid && !mis;
    utype = int'(bif.upd_type);
    ughr  = int'(bif.upd_ghr);
    ut    = bif.upd_taken;
    if (mis)                          mghr = (utype == 0) ? (((ughr << 1) | int'(ut)) & 15) : ughr;
    else if (acc && hit && ty == 0)   mghr = ((mghr << 1) | int'(tk)) & 15;
    if (acc && hit && ty == 2) begin
      mras.push_back(bif.pc + 64'd4);
      if (mras.size() > 4) void'(mras.pop_front());
    end
    if (acc && hit && ty == 3 && mras.size() > 0) void'(mras.pop_back());
    if (bif.upd_valid) begin
      ui = idx_of(bif.upd_pc);
      gi = ui ^ ughr;
      if (utype == 0) begin
        c1 = ((mp1[ui] >= 2) == ut);
        c2 = ((mp2[gi] >= 2) == ut);
        mp1[ui] = sat_step(mp1[ui], ut);
        mp2[gi] = sat_step(mp2[gi], ut);
        if (c1 && !c2) msel[ui] = sat_step(msel[ui], 1);
        if (!c1 && c2) msel[ui] = sat_step(msel[ui], 0);
      end
      if (ut) begin
        mv[ui] = 1; mtag[ui] = bif.upd_pc >> 6; mtype[ui] = utype; mtgt[ui] = bif.upd_target;
      end
    end
  endfunction

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin : compare
    bit tk, hit;
    logic [63:0] tg;
    int ty;
    if (reset) model_reset();
    model_predict(bif.pc, tk, tg, hit, ty);
    chk("ready",       64'(bif.ready),      64'(m_ready));
    chk("pred_taken",  64'(bif.pred_taken), 64'(tk));
    chk("pred_target", bif.pred_target,     tg);
    chk("pred_ghr",    64'(bif.pred_ghr),   64'(mghr));
    if (!reset) model_step(tk, hit, ty);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bif.pred_valid = 0; bif.upd_valid = 0; bif.upd_mispredict = 0;
  endtask

  task automatic pred(input logic [63:0] p, input bit v);
    bif.pc = p; bif.pred_valid = v;
  endtask

  task automatic upd(input logic [63:0] p, input logic [1:0] t, input bit tk,
                     input logic [63:0] tg, input logic [3:0] g, input bit mis);
    bif.upd_valid = 1; bif.upd_pc = p; bif.upd_type = t; bif.upd_taken = tk;
    bif.upd_target = tg; bif.upd_ghr = g; bif.upd_mispredict = mis;
  endtask

  task automatic expect_pred(input string nm, input bit tk, input logic [63:0] tg);
    @(negedge clk);
    chk({nm, "_taken"},  64'(bif.pred_taken), 64'(tk));
    chk({nm, "_target"}, bif.pred_target,     tg);
    tick();
  endtask

  task automatic expect_ready(input string nm, input bit r);
    @(negedge clk);
    chk(nm, 64'(bif.ready), 64'(r));
    tick();
  endtask

  task automatic expect_ghr(input string nm, input logic [3:0] g);
    @(negedge clk);
    chk(nm, 64'(bif.pred_ghr), 64'(g));
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rp, up, tagv;
    model_reset();
    idle();
    bif.pc = 0; bif.upd_pc = 0; bif.upd_target = 0; bif.upd_taken = 0;
    bif.upd_type = 0; bif.upd_ghr = 0;
    repeat (3) tick();
    reset = 0;

    // Init sweep: 16 cycles not ready, then ready; miss predicts fall-through
    for (int i = 0; i < 16; i++) expect_ready("init_ready", 1'b0);
    expect_ready("run_ready", 1'b1);
    pred(64'h100, 1);
    expect_pred("miss", 1'b0, 64'h104);
    idle();

    // Conditional branch trained taken, then twice not taken
    upd(64'h40, 2'b00, 1, 64'h80, 4'h0, 0); tick(); idle();
    pred(64'h40, 0);
    expect_pred("cond_t", 1'b1, 64'h80);
    upd(64'h40, 2'b00, 0, 64'h0, 4'h0, 0); tick(); tick(); idle();
    expect_pred("cond_nt", 1'b0, 64'h44);

    // Calls/returns through the RAS, including overflow and empty pop
    upd(64'h10,  2'b10, 1, 64'h200, 4'h0, 0); tick();
    upd(64'h14,  2'b10, 1, 64'h300, 4'h0, 0); tick();
    upd(64'h18,  2'b10, 1, 64'h400, 4'h0, 0); tick();
    upd(64'h20C, 2'b11, 1, 64'h14,  4'h0, 0); tick(); idle();
    pred(64'h10, 1);  expect_pred("call", 1'b1, 64'h200);
    pred(64'h20C, 1); expect_pred("ret",  1'b1, 64'h14);
    pred(64'h10, 1);  expect_pred("c1", 1'b1, 64'h200);
    pred(64'h14, 1);  expect_pred("c2", 1'b1, 64'h300);
    pred(64'h18, 1);  expect_pred("c3", 1'b1, 64'h400);
    pred(64'h10, 1);  expect_pred("c4", 1'b1, 64'h200);
    pred(64'h14, 1);  expect_pred("c5", 1'b1, 64'h300);
    pred(64'h20C, 1); expect_pred("r1", 1'b1, 64'h18);
    expect_pred("r2", 1'b1, 64'h14);
    expect_pred("r3", 1'b1, 64'h1C);
    expect_pred("r4", 1'b1, 64'h18);
    expect_pred("r_empty", 1'b0, 64'h210);
    idle();

    // Mispredict repair beats a same-cycle history shift
    upd(64'h0, 2'b01, 0, 64'h0, 4'b1011, 1); tick(); idle();
    expect_ghr("ghr_set", 4'b1011);
    pred(64'h40, 1);
    upd(64'h124, 2'b00, 1, 64'h500, 4'b0010, 1); tick(); idle();
    expect_ghr("ghr_repair", 4'b0101);

    // Selector training toward bimodal, then toward gshare
    upd(64'h30, 2'b00, 1, 64'h90, 4'h0, 0); tick();
    upd(64'h30, 2'b00, 0, 64'h90, 4'h0, 0); tick(); tick(); tick();
    upd(64'h30, 2'b00, 0, 64'h90, 4'h3, 0); tick();
    upd(64'h30, 2'b00, 0, 64'h90, 4'h5, 0); tick();
    upd(64'h30, 2'b00, 0, 64'h90, 4'h6, 0); tick();
    upd(64'h0, 2'b01, 0, 64'h0, 4'hF, 1); tick(); idle();
    pred(64'h30, 0); expect_pred("sel_p1", 1'b0, 64'h34);
    upd(64'h30, 2'b00, 1, 64'h90, 4'hF, 0); tick();
    upd(64'h30, 2'b00, 1, 64'h90, 4'hE, 0); tick();
    upd(64'h0, 2'b01, 0, 64'h0, 4'h0, 1); tick(); idle();
    expect_pred("sel_p2", 1'b0, 64'h34);

    // Reset in RUN, then again part-way through the sweep
    reset = 1; tick(); reset = 0;
    repeat (8) tick();
    reset = 1;
    expect_ready("reset_mid_init", 1'b0);
    reset = 0;
    for (int i = 0; i < 16; i++) expect_ready("reinit_ready", 1'b0);
    expect_ready("rerun_ready", 1'b1);
    pred(64'h40, 0); expect_pred("inv_cond", 1'b0, 64'h44);
    pred(64'h10, 0); expect_pred("inv_call", 1'b0, 64'h14);

    // Randomised traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: tagv = 64'h0;
        1: tagv = 64'h40;
        2: tagv = 64'h80;
        default: tagv = 64'hFFFF_FFFF_FFFF_FFC0;
      endcase
      rp = tagv | (64'($urandom_range(0, 15)) << 2);
      case ($urandom_range(0, 3))
        0: tagv = 64'h0;
        1: tagv = 64'h40;
        2: tagv = 64'h80;
        default: tagv = 64'hFFFF_FFFF_FFFF_FFC0;
      endcase
      up = tagv | (64'($urandom_range(0, 15)) << 2);
      bif.pc = rp;
      bif.pred_valid = $urandom_range(0, 3) != 0;
      bif.upd_valid = $urandom_range(0, 1);
      bif.upd_pc = up;
      bif.upd_type = 2'($urandom_range(0, 3));
      bif.upd_taken = (bif.upd_type == 2'b00) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      bif.upd_target = {$urandom, $urandom & 32'hFFFF_FFFC};
      bif.upd_ghr = 4'($urandom_range(0, 15));
      bif.upd_mispredict = $urandom_range(0, 5) == 0;
      reset = ($urandom_range(0, 999) == 0);
      tick();
      reset = 0;
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
